// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered RV32I/vector ALU op decode
// that replays vector ops as LANES-wide element beats.
module alu_op_sequencer #(
  parameter int NUM_ELEMS = 8,
  parameter int LANES     = 2,
  parameter int VL_W      = $clog2(NUM_ELEMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             R,
  input  logic             I,
  input  logic             U,
  input  logic             VR,
  input  logic             abs,
  input  logic [7:0]       decoded_f3,
  input  logic             f7_eq_0x0,
  input  logic             f7_eq_0x1,
  input  logic             f7_eq_0x20,
  input  logic [VL_W-1:0]  vl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ALU_op,
  output logic [VL_W-1:0]  elem_idx,
  output logic [LANES-1:0] lane_mask,
  output logic             last,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_DIV   = 4'd11;
  localparam logic [3:0] OP_REM   = 4'd12;
  localparam logic [3:0] OP_ABS   = 4'd13;
  localparam logic [3:0] OP_PASSB = 4'd14;
  localparam logic [3:0] OP_ILL   = 4'd15;

  // One extra bit so idx+lane never wraps.
  localparam int CW = VL_W + 1;
  localparam logic [CW-1:0] C_NE = CW'(NUM_ELEMS);
  localparam logic [CW-1:0] C_LN = CW'(LANES);
  localparam logic [VL_W-1:0] C_STEP = VL_W'(LANES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BEAT = 1'b1
  } state_t;

  state_t           r_state;
  logic [3:0]       r_op;
  logic             r_ill;
  logic [VL_W-1:0]  r_idx;
  logic [LANES-1:0] r_mask;
  logic             r_last;
  logic [CW-1:0]    r_vl;

  logic             w_f3_oh;
  logic [3:0]       w_base;
  logic [3:0]       w_alt;
  logic [3:0]       w_mext;
  logic [3:0]       w_op;
  logic             w_ill;
  logic             w_vec;
  logic [CW-1:0]    w_vl;
  logic [CW-1:0]    w_vleff;
  logic             w_drop;
  logic [LANES-1:0] w_mask0;
  logic             w_last0;
  logic             w_fire;
  logic             w_load;
  logic [VL_W-1:0]  w_nidx;
  logic [LANES-1:0] w_nmask;
  logic             w_nlast;

  function automatic logic [LANES-1:0] f_mask(
    input logic [CW-1:0] base,
    input logic [CW-1:0] lim
  );
    logic [LANES-1:0] m;
    m = '0;
    for (int j = 0; j < LANES; j++) begin
      m[j] = (base + CW'(j)) < lim;
    end
    return m;
  endfunction

  assign w_f3_oh = $onehot(decoded_f3);

  // funct3 table for base, funct7=0x20 and funct7=0x01 variants
  always_comb begin
    w_base = OP_ILL;
    w_alt  = OP_ILL;
    w_mext = OP_ILL;
    if (w_f3_oh) begin
      unique case (1'b1)
        decoded_f3[0]: begin
          w_base = OP_ADD;
          w_alt  = OP_SUB;
          w_mext = OP_MUL;
        end
        decoded_f3[1]: w_base = OP_SLL;
        decoded_f3[2]: w_base = OP_SLT;
        decoded_f3[3]: w_base = OP_SLTU;
        decoded_f3[4]: begin
          w_base = OP_XOR;
          w_mext = OP_DIV;
        end
        decoded_f3[5]: begin
          w_base = OP_SRL;
          w_alt  = OP_SRA;
        end
        decoded_f3[6]: begin
          w_base = OP_OR;
          w_mext = OP_REM;
        end
        decoded_f3[7]: w_base = OP_AND;
        default: ;
      endcase
    end
  end

  // Class priority: abs > U > R/VR > I > address add
  always_comb begin
    w_op = OP_ADD;
    if (abs) begin
      w_op = OP_ABS;
    end else if (U) begin
      w_op = OP_PASSB;
    end else if (R | VR) begin
      if (f7_eq_0x0)       w_op = w_base;
      else if (f7_eq_0x20) w_op = w_alt;
      else if (f7_eq_0x1)  w_op = w_mext;
      else                 w_op = OP_ILL;
    end else if (I) begin
      if (w_f3_oh && decoded_f3[5] && f7_eq_0x20)
        w_op = OP_SRA;
      else
        w_op = w_base;
    end
  end

  assign w_ill   = (w_op == OP_ILL);
  assign w_vec   = VR & ~w_ill;
  assign w_vl    = CW'(vl);
  assign w_vleff = (w_vl > C_NE) ? C_NE : w_vl;
  assign w_drop  = w_vec & (w_vleff == '0);
  assign w_mask0 = w_ill ? '0 :
                   w_vec ? f_mask('0, w_vleff) : '1;
  assign w_last0 = ~w_vec | (w_vleff <= C_LN);

  assign out_valid = (r_state == S_BEAT);
  assign w_fire    = out_valid & out_ready;
  assign in_ready  = ~out_valid | (w_fire & r_last);
  assign w_load    = in_valid & in_ready;

  assign w_nidx  = r_idx + C_STEP;
  assign w_nmask = f_mask(CW'(w_nidx), r_vl);
  assign w_nlast = (CW'(w_nidx) + C_LN) >= r_vl;

  assign ALU_op    = r_op;
  assign elem_idx  = r_idx;
  assign lane_mask = r_mask;
  assign last      = r_last;
  assign illegal   = r_ill;

  // Load on accept, step element beats on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
      r_ill   <= 1'b0;
      r_idx   <= '0;
      r_mask  <= '0;
      r_last  <= 1'b0;
      r_vl    <= '0;
    end else if (w_load) begin
      if (w_drop) begin
        r_state <= S_IDLE;
      end else begin
        r_state <= S_BEAT;
        r_op    <= w_op;
        r_ill   <= w_ill;
        r_idx   <= '0;
        r_mask  <= w_mask0;
        r_last  <= w_last0;
        r_vl    <= w_vleff;
      end
    end else if (w_fire) begin
      if (r_last) begin
        r_state <= S_IDLE;
      end else begin
        r_idx  <= w_nidx;
        r_mask <= w_nmask;
        r_last <= w_nlast;
      end
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Registered, parametrised successor to the combinational RV32I ALU decoder.
- Accepts one decoded instruction per handshake and produces the 4-bit ALU_op.
- For vector-register (VR) instructions, the same op is replayed as a sequence of element beats, LANES elements per beat, with per-beat index and lane mask.
- Sits between the decode stage and the scalar/vector ALU; it is the execute-issue point for the vector extension.

Parameters:
- NUM_ELEMS, 8: maximum vector length in elements.
- LANES, 2: elements processed per beat; must divide NUM_ELEMS.
- VL_W, $clog2(NUM_ELEMS+1): width of the vl input.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction available.
- in_ready  out  1  block can accept.
- R, I, U, VR, abs  in  1 each  instruction class flags from decode.
- decoded_f3  in  8  one-hot funct3.
- f7_eq_0x0, f7_eq_0x1, f7_eq_0x20  in  1 each  funct7 compare flags.
- vl  in  VL_W  active vector length; sampled only when VR=1.
- out_valid  out  1  beat valid.
- out_ready  in  1  ALU accepts beat.
- ALU_op  out  4  operation code.
- elem_idx  out  VL_W  index of first element in beat.
- lane_mask  out  LANES  active lanes in beat.
- last  out  1  final beat of instruction.
- illegal  out  1  decode failed.

Behaviour:
- ALU_op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA
  - 8 OR, 9 AND, 10 MUL, 11 DIV, 12 REM, 13 ABS, 14 PASSB, 15 ILLEGAL
- Decode priority: abs > U > (R|VR) > I > default.
  - abs → ABS.
  - U → PASSB.
  - R or VR with f7_eq_0x0: f3 = 0..7 → ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - R or VR with f7_eq_0x20: f3=0 → SUB; f3=5 → SRA; else ILLEGAL.
  - R or VR with f7_eq_0x1: f3=0 → MUL; f3=4 → DIV; f3=6 → REM; else ILLEGAL.
  - R or VR with no f7 flag set → ILLEGAL.
  - I: as R/f7=0, except f3=5 with f7_eq_0x20 → SRA.
  - No class flag set → ADD (address generation).
  - decoded_f3 not exactly one-hot → ILLEGAL whenever f3 is consulted.
- Decode occurs at accept and is registered. Outputs never change combinationally with inputs.
- FSM states: IDLE, BEAT.
  - IDLE: in_ready=1, out_valid=0.
  - Accept (in_valid & in_ready) → BEAT. out_valid=1 in the next cycle (1-cycle latency).
  - Scalar, illegal, or VR-with-illegal-op: exactly one beat. elem_idx=0, lane_mask=all-ones for scalar / all-zeros for illegal, last=1.
  - VR legal: beats = ceil(vl_eff/LANES), where vl_eff = min(vl, NUM_ELEMS).
    - elem_idx = 0, LANES, 2·LANES, …
    - lane_mask bit j set iff elem_idx+j < vl_eff.
    - last=1 on the final beat only.
  - VR with vl=0: no beats. Block stays in IDLE (in_ready stays 1), and the instruction is dropped.
- Handshake:
  - A beat advances only on out_valid & out_ready.
  - While out_valid & !out_ready, ALU_op, elem_idx, lane_mask, last and illegal are held stable.
  - in_ready = (state==IDLE) | (out_valid & out_ready & last). This allows back-to-back scalars at one per cycle.
  - A simultaneous final-beat consume and new accept loads the new instruction with no bubble.
  - If the final beat is consumed without a new accept → IDLE.
- Reset, asynchronous at any time including mid-sequence:
  - state=IDLE; out_valid=0, in_ready=1 after deassertion.
  - ALU_op=0, elem_idx=0, lane_mask=0, last=0, illegal=0.
  - The in-flight instruction is discarded.
- Inputs are ignored when not accepted; vl is not re-sampled mid-sequence.

Test Plan:
1. Scalar decode sweep: R, f7_eq_0x0, decoded_f3=0x01 → one beat, ALU_op=0, last=1. Then f7_eq_0x20 with f3=0x01 → 1. f7_eq_0x1 with f3=0x10 → 11. I with f3=0x20 and f7_eq_0x20 → 7. U → 14. abs → 13. No flags → 0.
2. Illegal: R, f7_eq_0x20, f3=0x02 → ALU_op=15, illegal=1, last=1. Also decoded_f3=0x03 → illegal.
3. Vector, vl=5, LANES=2, VR+ADD → 3 beats with elem_idx 0/2/4, lane_mask 11/11/01, last only on the third. in_ready=0 until the third beat is consumed.
4. Backpressure: out_ready=0 for 3 cycles mid-vector → outputs frozen, elem_idx unchanged. Resumes on out_ready=1.
5. Boundaries:
   - vl=0 → no out_valid, in_ready stays 1.
   - vl=12 (>8) → 4 beats, clamped.
   - Back-to-back scalars with out_ready=1 → one instruction per cycle.
6. Reset mid-vector (assert rst_n=0 during beat 2 of vl=8) → out_valid=0 immediately. After release, in_ready=1 and a new scalar decodes normally.
